// File: rtl/tour_move_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tour_move_sequencer
// Description : Replays a computed knight's tour as drive commands for the
//               command processor. In idle it passes UART commands straight
//               through; once a tour starts it owns the command path and
//               issues a vertical leg followed by a horizontal leg (with
//               fanfare) for every stored move.
// Revision    : 1.0 - initial release
// ============================================================================
module tour_move_sequencer #(
    parameter int NUM_MOVES = 24,
    parameter int IDX_W     = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_tour,
    input  logic [7:0]       move,
    output logic [IDX_W-1:0] mv_indx,
    input  logic [15:0]      cmd_UART,
    input  logic             cmd_rdy_UART,
    output logic             clr_cmd_rdy_UART,
    output logic [15:0]      cmd,
    output logic             cmd_rdy,
    input  logic             clr_cmd_rdy,
    input  logic             send_resp,
    output logic [7:0]       resp,
    output logic             tour_active
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [3:0]       c_OP_MOVE    = 4'h4;
    localparam logic [3:0]       c_OP_FANFARE = 4'h5;
    localparam logic [7:0]       c_HDG_NORTH  = 8'h00;
    localparam logic [7:0]       c_HDG_WEST   = 8'h3F;
    localparam logic [7:0]       c_HDG_SOUTH  = 8'h7F;
    localparam logic [7:0]       c_HDG_EAST   = 8'hBF;
    localparam logic [7:0]       c_RESP_IDLE  = 8'hA5;
    localparam logic [7:0]       c_RESP_BUSY  = 8'h5A;
    localparam logic [IDX_W-1:0] c_LAST_IDX   = IDX_W'(NUM_MOVES - 1);
    localparam logic [IDX_W-1:0] c_IDX_ONE    = IDX_W'(1);

    // ------------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VERT   = 3'd1,
        WAIT_V = 3'd2,
        HORZ   = 3'd3,
        WAIT_H = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [IDX_W-1:0] r_mv_indx;
    logic [IDX_W-1:0] w_next_mv_indx;
    logic             r_tour_active;

    // Decoded move: sign and magnitude of each displacement component
    logic             w_dx_pos;
    logic             w_dy_pos;
    logic [3:0]       w_dx_mag;
    logic [3:0]       w_dy_mag;
    logic [15:0]      w_vert_cmd;
    logic [15:0]      w_horz_cmd;
    logic             w_last_move;

    assign w_last_move = (r_mv_indx == c_LAST_IDX);

    // Decode the one-hot move into (dx, dy); anything not one-hot falls back to bit0
    always_comb begin
        w_dx_pos = 1'b1;
        w_dy_pos = 1'b1;
        w_dx_mag = 4'd1;
        w_dy_mag = 4'd2;
        case (move)
            8'h01: begin w_dx_pos = 1'b1; w_dx_mag = 4'd1; w_dy_pos = 1'b1; w_dy_mag = 4'd2; end
            8'h02: begin w_dx_pos = 1'b0; w_dx_mag = 4'd1; w_dy_pos = 1'b1; w_dy_mag = 4'd2; end
            8'h04: begin w_dx_pos = 1'b0; w_dx_mag = 4'd2; w_dy_pos = 1'b1; w_dy_mag = 4'd1; end
            8'h08: begin w_dx_pos = 1'b0; w_dx_mag = 4'd2; w_dy_pos = 1'b0; w_dy_mag = 4'd1; end
            8'h10: begin w_dx_pos = 1'b0; w_dx_mag = 4'd1; w_dy_pos = 1'b0; w_dy_mag = 4'd2; end
            8'h20: begin w_dx_pos = 1'b1; w_dx_mag = 4'd1; w_dy_pos = 1'b0; w_dy_mag = 4'd2; end
            8'h40: begin w_dx_pos = 1'b1; w_dx_mag = 4'd2; w_dy_pos = 1'b0; w_dy_mag = 4'd1; end
            8'h80: begin w_dx_pos = 1'b1; w_dx_mag = 4'd2; w_dy_pos = 1'b1; w_dy_mag = 4'd1; end
            default: begin
                w_dx_pos = 1'b1;
                w_dx_mag = 4'd1;
                w_dy_pos = 1'b1;
                w_dy_mag = 4'd2;
            end
        endcase
    end

    // Build the two leg commands: vertical is a plain move, horizontal carries fanfare
    always_comb begin
        w_vert_cmd = {c_OP_MOVE,    (w_dy_pos ? c_HDG_NORTH : c_HDG_SOUTH), w_dy_mag};
        w_horz_cmd = {c_OP_FANFARE, (w_dx_pos ? c_HDG_EAST  : c_HDG_WEST),  w_dx_mag};
    end

    // Next-state and move-index logic; send_resp only counts once the leg was consumed
    always_comb begin
        w_next_state   = r_state;
        w_next_mv_indx = r_mv_indx;
        case (r_state)
            IDLE: begin
                if (start_tour) begin
                    w_next_state   = VERT;
                    w_next_mv_indx = '0;
                end
            end
            VERT: begin
                if (clr_cmd_rdy) begin
                    w_next_state = WAIT_V;
                end
            end
            WAIT_V: begin
                if (send_resp) begin
                    w_next_state = HORZ;
                end
            end
            HORZ: begin
                if (clr_cmd_rdy) begin
                    w_next_state = WAIT_H;
                end
            end
            WAIT_H: begin
                if (send_resp) begin
                    if (w_last_move) begin
                        w_next_state = IDLE;
                    end else begin
                        w_next_state   = VERT;
                        w_next_mv_indx = r_mv_indx + c_IDX_ONE;
                    end
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State, move index and activity flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_mv_indx     <= '0;
            r_tour_active <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_mv_indx     <= w_next_mv_indx;
            r_tour_active <= (w_next_state != IDLE);
        end
    end

    // Command-path mux: pass-through in idle, sequencer-owned otherwise.
    // UART consume strobe is gated during a tour so pending commands are held.
    always_comb begin
        cmd              = w_vert_cmd;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        resp             = c_RESP_BUSY;
        case (r_state)
            IDLE: begin
                cmd              = cmd_UART;
                cmd_rdy          = cmd_rdy_UART;
                clr_cmd_rdy_UART = clr_cmd_rdy;
                resp             = c_RESP_IDLE;
            end
            VERT: begin
                cmd     = w_vert_cmd;
                cmd_rdy = 1'b1;
            end
            WAIT_V: begin
                cmd = w_vert_cmd;
            end
            HORZ: begin
                cmd     = w_horz_cmd;
                cmd_rdy = 1'b1;
            end
            WAIT_H: begin
                cmd = w_horz_cmd;
                // Final response of the tour tells the host it is complete
                if (w_last_move) begin
                    resp = c_RESP_IDLE;
                end
            end
            default: begin
                cmd     = w_vert_cmd;
                cmd_rdy = 1'b0;
            end
        endcase
    end

    assign mv_indx     = r_mv_indx;
    assign tour_active = r_tour_active;

endmodule
`default_nettype wire

// File: tb/tb_tour_move_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_tour_move_sequencer
// Description : Self-checking bench for tour_move_sequencer. Expected leg
//               commands are queued when a tour is launched and compared as
//               the sequencer presents each command.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tour_move_sequencer;

    localparam int NM = 24;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_tour;
    logic [7:0]    move;
    logic [IW-1:0] mv_indx;
    logic [15:0]   cmd_UART;
    logic          cmd_rdy_UART;
    logic          clr_cmd_rdy_UART;
    logic [15:0]   cmd;
    logic          cmd_rdy;
    logic          clr_cmd_rdy;
    logic          send_resp;
    logic [7:0]    resp;
    logic          tour_active;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] sb_cmd[$];
    int          sb_idx[$];

    logic [7:0] tour_mem[NM];

    // Leg-assertion monitor
    bit mon_en   = 1'b0;
    bit mon_prev = 1'b0;
    bit mon_now;
    int rdy_count = 0;

    always #5 clk = ~clk;

    // Tour memory is a combinational read at the presented index
    assign move = (int'(mv_indx) < NM) ? tour_mem[mv_indx] : 8'h00;

    tour_move_sequencer #(.NUM_MOVES(NM), .IDX_W(IW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_tour       (start_tour),
        .move             (move),
        .mv_indx          (mv_indx),
        .cmd_UART         (cmd_UART),
        .cmd_rdy_UART     (cmd_rdy_UART),
        .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
        .cmd              (cmd),
        .cmd_rdy          (cmd_rdy),
        .clr_cmd_rdy      (clr_cmd_rdy),
        .send_resp        (send_resp),
        .resp             (resp),
        .tour_active      (tour_active)
    );

    // Count rising edges of "sequencer is asserting a command"
    always @(negedge clk) begin
        mon_now = tour_active && cmd_rdy;
        if (mon_en && mon_now && !mon_prev) rdy_count++;
        mon_prev = mon_now;
    end

    // Reference leg command from the move table (dx, dy per bit)
    function automatic logic [15:0] exp_leg(input logic [7:0] m, input bit horiz);
        int dx[8];
        int dy[8];
        int sel;
        int mag;
        dx = '{1, -1, -2, -2, -1, 1, 2, 2};
        dy = '{2, 2, 1, -1, -2, -2, -1, 1};
        sel = 0;
        if ($countones(m) == 1) begin
            for (int b = 0; b < 8; b++) if (m[b]) sel = b;
        end
        if (horiz) begin
            mag = (dx[sel] > 0) ? dx[sel] : -dx[sel];
            return {4'h5, ((dx[sel] > 0) ? 8'hBF : 8'h3F), 4'(mag)};
        end
        mag = (dy[sel] > 0) ? dy[sel] : -dy[sel];
        return {4'h4, ((dy[sel] > 0) ? 8'h00 : 8'h7F), 4'(mag)};
    endfunction

    task automatic push_tour();
        for (int i = 0; i < NM; i++) begin
            sb_cmd.push_back(exp_leg(tour_mem[i], 1'b0)); sb_idx.push_back(i);
            sb_cmd.push_back(exp_leg(tour_mem[i], 1'b1)); sb_idx.push_back(i);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start_tour = 1'b1;
        @(posedge clk); #1 start_tour = 1'b0;
    endtask

    // Acts as cmd_proc: consume each leg, respond, and score it.
    // Returns with stopped=1 when the next leg belongs to stop_idx.
    task automatic serve_tour(input int stop_idx, output bit stopped);
        logic [15:0] ecmd;
        int eidx;
        int k;
        bit vert;
        stopped = 1'b0;
        vert    = 1'b1;
        while (sb_cmd.size() > 0) begin
            @(negedge clk);
            k = 0;
            while (!cmd_rdy && k < 20) begin @(negedge clk); k++; end
            n_tests++;
            if (k != 0) begin
                n_fail++;
                $display("FAIL cmd_rdy_latency: waited %0d cycles, required 0", k);
            end
            if (!cmd_rdy) begin
                sb_cmd.delete(); sb_idx.delete();
                return;
            end
            if (sb_idx[0] == stop_idx) begin
                stopped = 1'b1;
                return;
            end
            ecmd = sb_cmd.pop_front();
            eidx = sb_idx.pop_front();
            n_tests++;
            if (cmd !== ecmd) begin
                n_fail++;
                $display("FAIL leg_cmd idx %0d: got %h required %h", eidx, cmd, ecmd);
            end
            n_tests++;
            if (int'(mv_indx) != eidx) begin
                n_fail++;
                $display("FAIL mv_indx: got %0d required %0d", mv_indx, eidx);
            end
            n_tests++;
            if (resp !== 8'h5A || tour_active !== 1'b1) begin
                n_fail++;
                $display("FAIL busy_flags: resp %h active %b required 5a 1", resp, tour_active);
            end
            if (vert) begin
                // send_resp before the leg is consumed must be ignored
                @(posedge clk); #1 send_resp = 1'b1;
                @(posedge clk); #1 send_resp = 1'b0;
                @(negedge clk);
                n_tests++;
                if (cmd_rdy !== 1'b1 || cmd !== ecmd) begin
                    n_fail++;
                    $display("FAIL early_send_resp: cmd_rdy %b cmd %h required 1 %h", cmd_rdy, cmd, ecmd);
                end
            end
            // consume; on vertical legs send_resp arrives in the same cycle
            @(posedge clk); #1 clr_cmd_rdy = 1'b1; send_resp = vert;
            @(negedge clk);
            n_tests++;
            if (clr_cmd_rdy_UART !== 1'b0) begin
                n_fail++;
                $display("FAIL uart_clr_gated: got %b required 0", clr_cmd_rdy_UART);
            end
            @(posedge clk); #1 clr_cmd_rdy = 1'b0; send_resp = 1'b0;
            @(negedge clk);
            n_tests++;
            if (cmd_rdy !== 1'b0) begin
                n_fail++;
                $display("FAIL cmd_rdy_drop: got %b required 0", cmd_rdy);
            end
            n_tests++;
            if (resp !== ((sb_cmd.size() == 0) ? 8'hA5 : 8'h5A)) begin
                n_fail++;
                $display("FAIL wait_resp idx %0d: got %h required %h", eidx, resp,
                         (sb_cmd.size() == 0) ? 8'hA5 : 8'h5A);
            end
            @(posedge clk); #1 send_resp = 1'b1;
            @(posedge clk); #1 send_resp = 1'b0;
            vert = !vert;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if (tour_active !== 1'b0 || mv_indx !== '0 || resp !== 8'hA5 || cmd_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: active %b idx %0d resp %h rdy %b required 0 0 a5 0",
                     tour_active, mv_indx, resp, cmd_rdy);
        end
        clr_cmd_rdy = 1'b1;
        #1;
        n_tests++;
        if (clr_cmd_rdy_UART !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_clr_follow: got %b required 1", clr_cmd_rdy_UART);
        end
        clr_cmd_rdy = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_passthrough();
        @(posedge clk); #1 cmd_UART = 16'h2000; cmd_rdy_UART = 1'b1;
        @(negedge clk);
        n_tests++;
        if (cmd !== 16'h2000 || cmd_rdy !== 1'b1 || resp !== 8'hA5) begin
            n_fail++;
            $display("FAIL passthrough: cmd %h rdy %b resp %h required 2000 1 a5", cmd, cmd_rdy, resp);
        end
        @(posedge clk); #1 clr_cmd_rdy = 1'b1;
        @(negedge clk);
        n_tests++;
        if (clr_cmd_rdy_UART !== 1'b1) begin
            n_fail++;
            $display("FAIL passthrough_clr: got %b required 1", clr_cmd_rdy_UART);
        end
        @(posedge clk); #1 clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;
        @(negedge clk);
        n_tests++;
        if (clr_cmd_rdy_UART !== 1'b0 || cmd_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL passthrough_idle: clr %b rdy %b required 0 0", clr_cmd_rdy_UART, cmd_rdy);
        end
    endtask

    // Full tour: decode sweep, non-one-hot fallback, arbitration against a held UART command
    task automatic test_full_tour();
        bit st;
        for (int i = 0; i < 16; i++) tour_mem[i] = 8'h01 << (i % 8);
        tour_mem[3]  = 8'h08;
        tour_mem[16] = 8'h00;
        tour_mem[17] = 8'hFF;
        tour_mem[18] = 8'h81;
        for (int i = 19; i < NM; i++) tour_mem[i] = 8'h01 << $urandom_range(7, 0);
        cmd_UART     = 16'h1234;
        cmd_rdy_UART = 1'b1;
        push_tour();
        rdy_count = 0;
        mon_en    = 1'b1;
        pulse_start();
        serve_tour(-1, st);
        mon_en = 1'b0;
        n_tests++;
        if (rdy_count != 2 * NM) begin
            n_fail++;
            $display("FAIL leg_count: got %0d required %0d", rdy_count, 2 * NM);
        end
        @(negedge clk);
        n_tests++;
        if (tour_active !== 1'b0 || cmd !== 16'h1234 || cmd_rdy !== 1'b1 || resp !== 8'hA5) begin
            n_fail++;
            $display("FAIL tour_end: active %b cmd %h rdy %b resp %h required 0 1234 1 a5",
                     tour_active, cmd, cmd_rdy, resp);
        end
        @(posedge clk); #1 clr_cmd_rdy = 1'b1;
        @(negedge clk);
        n_tests++;
        if (clr_cmd_rdy_UART !== 1'b1) begin
            n_fail++;
            $display("FAIL pending_uart_clr: got %b required 1", clr_cmd_rdy_UART);
        end
        @(posedge clk); #1 clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;
    endtask

    task automatic test_reset_mid_tour();
        bit st;
        bit bad;
        for (int i = 0; i < NM; i++) tour_mem[i] = 8'h01 << $urandom_range(7, 0);
        push_tour();
        pulse_start();
        serve_tour(7, st);
        n_tests++;
        if (!st) begin
            n_fail++;
            $display("FAIL reach_idx7: stopped %b required 1", st);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (tour_active !== 1'b0 || mv_indx !== '0 || cmd_rdy !== 1'b0 || resp !== 8'hA5) begin
            n_fail++;
            $display("FAIL async_reset: active %b idx %0d rdy %b resp %h required 0 0 0 a5",
                     tour_active, mv_indx, cmd_rdy, resp);
        end
        sb_cmd.delete();
        sb_idx.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (cmd_rdy !== 1'b0 || tour_active !== 1'b0) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL post_reset_quiet: activity seen after reset, required none");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        start_tour   = 1'b0;
        cmd_UART     = 16'h0000;
        cmd_rdy_UART = 1'b0;
        clr_cmd_rdy  = 1'b0;
        send_resp    = 1'b0;
        for (int i = 0; i < NM; i++) tour_mem[i] = 8'h01;
        test_reset();
        test_passthrough();
        test_full_tour();
        test_reset_mid_tour();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
